// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game sequencer.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROUND_INIT,
        SHOW_ON,
        SHOW_OFF,
        PLAYER,
        ROUND_DONE,
        WIN,
        LOSE
    } state_t;

    localparam logic [2:0]  SPEED_MAX     = 3'd7;
    localparam int unsigned MAX_ROUND_DEF = 20;

    // Speed code for a round: round index divided by the (power-of-two)
    // rounds-per-step, saturating at SPEED_MAX.
    function automatic logic [2:0] speed_for_round(input logic [4:0]  round,
                                                   input int unsigned shift);
        logic [4:0] steps;
        steps = round >> shift;
        if (steps > 5'(SPEED_MAX)) begin
            return SPEED_MAX;
        end
        return steps[2:0];
    endfunction

endpackage

// File: rtl/simon_game_ctrl.sv
// Game sequencer: replays the colour sequence, hands control to the player,
// checks each entry, ramps speed every few rounds and reports win/lose.
// Every output is registered and decoded from the next state, so outputs
// line up with the state they describe.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_ROUND      = MAX_ROUND_DEF,
    parameter int unsigned SPEED_STEP     = 4,
    parameter int unsigned TIMEOUT_PULSES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       pulse,
    input  logic       empty,
    input  logic       result,
    output logic       start,
    output logic       rst_seedgen,
    output logic       load_colour,
    output logic       load_speed,
    output logic [2:0] speed,
    output logic       flash_clk,
    output logic [4:0] check_round,
    output logic       player_turn,
    output logic       game_over,
    output logic       win
);

    localparam int unsigned      SPEED_SHIFT = $clog2(SPEED_STEP);
    localparam int unsigned      TMO_W       = $clog2(TIMEOUT_PULSES + 1);
    localparam logic [4:0]       LAST_ROUND  = 5'(MAX_ROUND - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT   = TMO_W'(TIMEOUT_PULSES);

    state_t           state_q, state_d;
    logic [4:0]       round_q, round_d;
    logic [4:0]       step_q, step_d;
    logic [4:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tmo_inc;
    logic [2:0]       speed_q, speed_d;
    logic             start_q, start_d;
    logic             seedgen_q, seedgen_d;
    logic             load_colour_q, load_colour_d;
    logic             load_speed_q, load_speed_d;
    logic             flash_q, flash_d;
    logic             player_q, player_d;
    logic             over_q, over_d;
    logic             win_q, win_d;
    logic             entry;

    assign entry   = ~empty;
    assign tmo_inc = tmo_q + TMO_W'(1);

    // Next-state, counter updates and registered-output decode.
    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        step_d        = step_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        speed_d       = speed_q;
        start_d       = 1'b0;
        load_speed_d  = 1'b0;
        load_colour_d = 1'b0;
        flash_d       = 1'b0;
        player_d      = 1'b0;
        over_d        = 1'b0;
        win_d         = 1'b0;
        seedgen_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    start_d = 1'b1;
                    round_d = '0;
                    speed_d = '0;
                    state_d = ROUND_INIT;
                end
            end
            ROUND_INIT: begin
                speed_d      = speed_for_round(round_q, SPEED_SHIFT);
                load_speed_d = 1'b1;
                step_d       = '0;
                state_d      = SHOW_ON;
            end
            SHOW_ON: begin
                if (pulse) begin
                    state_d = SHOW_OFF;
                end
            end
            SHOW_OFF: begin
                if (pulse) begin
                    if (step_q == round_q) begin
                        step_d  = '0;
                        idx_d   = '0;
                        tmo_d   = '0;
                        state_d = PLAYER;
                    end else begin
                        step_d  = step_q + 5'd1;
                        state_d = SHOW_ON;
                    end
                end
            end
            PLAYER: begin
                // An entry takes priority over a timeout pulse in the same cycle.
                if (entry) begin
                    if (!result) begin
                        state_d = LOSE;
                    end else if (idx_q == round_q) begin
                        state_d = ROUND_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        tmo_d = '0;
                    end
                end else if (pulse) begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_d = LOSE;
                    end
                end
            end
            ROUND_DONE: begin
                if (round_q == LAST_ROUND) begin
                    state_d = WIN;
                end else begin
                    round_d = round_q + 5'd1;
                    state_d = ROUND_INIT;
                end
            end
            WIN, LOSE: begin
                if (go) begin
                    round_d = '0;
                    step_d  = '0;
                    idx_d   = '0;
                    tmo_d   = '0;
                    speed_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_colour_d = (state_d == SHOW_ON) && (state_q != SHOW_ON);
        flash_d       = (state_d == SHOW_ON);
        if ((state_q == WIN) && (state_d == WIN)) begin
            flash_d = flash_q ^ pulse;
        end
        player_d  = (state_d == PLAYER);
        over_d    = (state_d == WIN) || (state_d == LOSE);
        win_d     = (state_d == WIN);
        seedgen_d = (state_d == IDLE);
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            round_q       <= '0;
            step_q        <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            speed_q       <= '0;
            start_q       <= 1'b0;
            seedgen_q     <= 1'b1;
            load_colour_q <= 1'b0;
            load_speed_q  <= 1'b0;
            flash_q       <= 1'b0;
            player_q      <= 1'b0;
            over_q        <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            step_q        <= step_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            speed_q       <= speed_d;
            start_q       <= start_d;
            seedgen_q     <= seedgen_d;
            load_colour_q <= load_colour_d;
            load_speed_q  <= load_speed_d;
            flash_q       <= flash_d;
            player_q      <= player_d;
            over_q        <= over_d;
            win_q         <= win_d;
        end
    end

    assign start       = start_q;
    assign rst_seedgen = seedgen_q;
    assign load_colour = load_colour_q;
    assign load_speed  = load_speed_q;
    assign speed       = speed_q;
    assign flash_clk   = flash_q;
    assign check_round = round_q;
    assign player_turn = player_q;
    assign game_over   = over_q;
    assign win         = win_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl: a 32-round instance and a
// 2-round instance, with expected speed codes queued per round and
// compared whenever load_speed fires.
module tb_simon_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       go_v[2], pulse_v[2], empty_v[2], result_v[2];
    logic       start_v[2], rsg_v[2], lc_v[2], ls_v[2], fl_v[2];
    logic       pt_v[2], over_v[2], win_v[2];
    logic [2:0] spd_v[2];
    logic [4:0] cr_v[2];

    int checks = 0;
    int errors = 0;
    int lc_cnt[2];
    int spd_q0[$];
    int spd_q1[$];
    int maxr[2];

    simon_game_ctrl #(.MAX_ROUND(32), .SPEED_STEP(4), .TIMEOUT_PULSES(16)) dut0 (
        .clk(clk), .rst(rst), .go(go_v[0]), .pulse(pulse_v[0]),
        .empty(empty_v[0]), .result(result_v[0]), .start(start_v[0]),
        .rst_seedgen(rsg_v[0]), .load_colour(lc_v[0]), .load_speed(ls_v[0]),
        .speed(spd_v[0]), .flash_clk(fl_v[0]), .check_round(cr_v[0]),
        .player_turn(pt_v[0]), .game_over(over_v[0]), .win(win_v[0])
    );

    simon_game_ctrl #(.MAX_ROUND(2), .SPEED_STEP(4), .TIMEOUT_PULSES(16)) dut1 (
        .clk(clk), .rst(rst), .go(go_v[1]), .pulse(pulse_v[1]),
        .empty(empty_v[1]), .result(result_v[1]), .start(start_v[1]),
        .rst_seedgen(rsg_v[1]), .load_colour(lc_v[1]), .load_speed(ls_v[1]),
        .speed(spd_v[1]), .flash_clk(fl_v[1]), .check_round(cr_v[1]),
        .player_turn(pt_v[1]), .game_over(over_v[1]), .win(win_v[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_speed(input int r);
        int v;
        v = r / 4;
        if (v > 7) v = 7;
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_speed(input int sel, input int r);
        if (sel == 0) spd_q0.push_back(exp_speed(r));
        else          spd_q1.push_back(exp_speed(r));
    endtask

    // Scoreboard side: every load_speed pops the expected speed code.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (lc_v[d] === 1'b1) lc_cnt[d]++;
            if (ls_v[d] === 1'b1) begin
                if (d == 0) begin
                    if (spd_q0.size() == 0) chk("ls_unexpected0", int'(ls_v[d]), 0);
                    else chk("speed0", int'(spd_v[d]), spd_q0.pop_front());
                end else begin
                    if (spd_q1.size() == 0) chk("ls_unexpected1", int'(ls_v[d]), 0);
                    else chk("speed1", int'(spd_v[d]), spd_q1.pop_front());
                end
            end
        end
    end

    task automatic chk_reset(input int sel);
        chk("rst_seedgen", int'(rsg_v[sel]), 1);
        chk("rst_start", int'(start_v[sel]), 0);
        chk("rst_load_colour", int'(lc_v[sel]), 0);
        chk("rst_load_speed", int'(ls_v[sel]), 0);
        chk("rst_speed", int'(spd_v[sel]), 0);
        chk("rst_flash", int'(fl_v[sel]), 0);
        chk("rst_check_round", int'(cr_v[sel]), 0);
        chk("rst_player_turn", int'(pt_v[sel]), 0);
        chk("rst_game_over", int'(over_v[sel]), 0);
        chk("rst_win", int'(win_v[sel]), 0);
    endtask

    task automatic press_go(input int sel);
        go_v[sel] = 1'b1;
        cyc();
        go_v[sel] = 1'b0;
        chk("start_high", int'(start_v[sel]), 1);
        chk("seedgen_low", int'(rsg_v[sel]), 0);
        chk("go_round_zero", int'(cr_v[sel]), 0);
        push_speed(sel, 0);
    endtask

    task automatic go_to_idle(input int sel);
        go_v[sel] = 1'b1;
        cyc();
        go_v[sel] = 1'b0;
        chk("idle_seedgen", int'(rsg_v[sel]), 1);
        chk("idle_game_over", int'(over_v[sel]), 0);
        chk("idle_win", int'(win_v[sel]), 0);
        chk("idle_round", int'(cr_v[sel]), 0);
        cyc();
        chk("idle_start_low", int'(start_v[sel]), 0);
        chk("idle_seedgen_hold", int'(rsg_v[sel]), 1);
    endtask

    // Called with ROUND_INIT visible; returns with PLAYER visible.
    task automatic do_replay(input int sel, input int cr);
        lc_cnt[sel] = 0;
        cyc();
        chk("start_one_cycle", int'(start_v[sel]), 0);
        chk("load_speed", int'(ls_v[sel]), 1);
        chk("load_colour_first", int'(lc_v[sel]), 1);
        for (int i = 0; i <= cr; i++) begin
            cyc();
            chk("flash_on", int'(fl_v[sel]), 1);
            chk("pt_in_replay", int'(pt_v[sel]), 0);
            pulse_v[sel] = 1'b1;
            cyc();
            pulse_v[sel] = 1'b0;
            chk("flash_off", int'(fl_v[sel]), 0);
            cyc();
            chk("pt_before_last_pulse", int'(pt_v[sel]), 0);
            pulse_v[sel] = 1'b1;
            cyc();
            pulse_v[sel] = 1'b0;
        end
        chk("player_turn_rise", int'(pt_v[sel]), 1);
        chk("load_colour_count", lc_cnt[sel], cr + 1);
    endtask

    // Enters cr+1 entries; entry 'bad' is wrong (-1 = none). 'g' pulses
    // precede each entry; 'pw' drives a pulse alongside the entry itself.
    task automatic do_entries(input int sel, input int cr, input int bad,
                              input int g, input logic pw);
        for (int e = 0; e <= cr; e++) begin
            for (int k = 0; k < g; k++) begin
                pulse_v[sel] = 1'b1;
                cyc();
                pulse_v[sel] = 1'b0;
            end
            if (g > 0) chk("pt_after_gap", int'(pt_v[sel]), 1);
            empty_v[sel]  = 1'b0;
            result_v[sel] = (e != bad);
            pulse_v[sel]  = pw;
            cyc();
            empty_v[sel]  = 1'b1;
            result_v[sel] = 1'b0;
            pulse_v[sel]  = 1'b0;
            if (e == bad) begin
                chk("lose_game_over", int'(over_v[sel]), 1);
                chk("lose_win", int'(win_v[sel]), 0);
                chk("lose_player_turn", int'(pt_v[sel]), 0);
                chk("lose_round_hold", int'(cr_v[sel]), cr);
                return;
            end
            if (e < cr) begin
                chk("pt_hold", int'(pt_v[sel]), 1);
                cyc();
            end else begin
                chk("pt_fall", int'(pt_v[sel]), 0);
                if (cr < maxr[sel] - 1) push_speed(sel, cr + 1);
                cyc();
                if (cr == maxr[sel] - 1) begin
                    chk("win_flag", int'(win_v[sel]), 1);
                    chk("win_game_over", int'(over_v[sel]), 1);
                    chk("win_player_turn", int'(pt_v[sel]), 0);
                end else begin
                    chk("round_next", int'(cr_v[sel]), cr + 1);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            go_v[d]     = 1'b0;
            pulse_v[d]  = 1'b0;
            empty_v[d]  = 1'b1;
            result_v[d] = 1'b0;
            lc_cnt[d]   = 0;
        end
        maxr[0] = 32;
        maxr[1] = 2;
        rst = 1'b1;
        repeat (3) cyc();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        cyc();
        chk("idle_seedgen_after_rst", int'(rsg_v[0]), 1);

        // Reach round 3, then reset asynchronously during SHOW_ON.
        press_go(0);
        for (int cr = 0; cr <= 2; cr++) begin
            do_replay(0, cr);
            do_entries(0, cr, -1, 0, 1'b0);
        end
        cyc();
        chk("pre_rst_round", int'(cr_v[0]), 3);
        chk("pre_rst_flash", int'(fl_v[0]), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_flash", int'(fl_v[0]), 0);
        chk("async_rst_seedgen", int'(rsg_v[0]), 1);
        cyc();
        chk_reset(0);
        rst = 1'b0;
        cyc();

        // Rounds with entry gaps, entry racing a timeout pulse, then a wrong entry.
        press_go(0);
        do_replay(0, 0);
        do_entries(0, 0, -1, 0, 1'b0);
        do_replay(0, 1);
        do_entries(0, 1, -1, 10, 1'b0);
        do_replay(0, 2);
        do_entries(0, 2, -1, 15, 1'b1);
        do_replay(0, 3);
        do_entries(0, 3, -1, 0, 1'b0);
        do_replay(0, 4);
        do_entries(0, 4, 1, 0, 1'b0);
        empty_v[0]  = 1'b0;
        result_v[0] = 1'b1;
        pulse_v[0]  = 1'b1;
        cyc();
        empty_v[0]  = 1'b0;
        result_v[0] = 1'b0;
        empty_v[0]  = 1'b1;
        pulse_v[0]  = 1'b0;
        chk("lose_ignores_entry", int'(over_v[0]), 1);
        chk("lose_flash_low", int'(fl_v[0]), 0);
        chk("lose_round_still", int'(cr_v[0]), 4);
        go_to_idle(0);

        // Full 32-round game: speed ramps 0..7 without wrapping, then WIN.
        press_go(0);
        for (int cr = 0; cr <= 31; cr++) begin
            do_replay(0, cr);
            do_entries(0, cr, -1, 0, 1'b0);
        end
        chk("top_speed", int'(spd_v[0]), 7);
        chk("top_round", int'(cr_v[0]), 31);
        go_to_idle(0);

        // Timeout: 15 pulses survive, the 16th loses.
        press_go(0);
        do_replay(0, 0);
        for (int k = 0; k < 15; k++) begin
            pulse_v[0] = 1'b1;
            cyc();
            pulse_v[0] = 1'b0;
        end
        chk("timeout_15_alive", int'(pt_v[0]), 1);
        pulse_v[0] = 1'b1;
        cyc();
        pulse_v[0] = 1'b0;
        chk("timeout_lose", int'(over_v[0]), 1);
        chk("timeout_win", int'(win_v[0]), 0);
        chk("timeout_pt", int'(pt_v[0]), 0);
        go_to_idle(0);

        // Two-round game on the small instance: win and celebration flashing.
        press_go(1);
        do_replay(1, 0);
        do_entries(1, 0, -1, 0, 1'b0);
        do_replay(1, 1);
        do_entries(1, 1, -1, 0, 1'b0);
        chk("win_flash_start", int'(fl_v[1]), 0);
        for (int t = 0; t < 4; t++) begin
            pulse_v[1] = 1'b1;
            cyc();
            pulse_v[1] = 1'b0;
            chk("win_flash_toggle", int'(fl_v[1]), (t + 1) % 2);
            cyc();
            chk("win_flash_hold", int'(fl_v[1]), (t + 1) % 2);
        end
        go_to_idle(1);

        chk("speed_queue0_drained", spd_q0.size(), 0);
        chk("speed_queue1_drained", spd_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
